ps2_receiver: RTL

Front-end stage of the keyboard path, directly upstream of the scancode-to-ASCII translation in keyboard. Runs in the clk_usb domain (48 MHz). It synchronizes and deglitches the raw PS/2 clock/data pins, deframes 11-bit device-to-host frames, and checks start, odd parity and stop bits. Good scancode bytes are presented on a one-entry valid/ready output register; error and overflow events are reported as single-cycle pulses.

---
 rtl/ps2_receiver_if.sv | 25 ++
 rtl/ps2_receiver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver_if.sv
// Output-side bundle of the PS/2 receiver: one-entry valid/ready byte channel
// plus the single-cycle error/overflow event pulses.
interface ps2_receiver_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_error;
  logic       overflow;

  modport master (
    output data,
    output valid,
    input  ready,
    output frame_error,
    output overflow
  );

  modport slave (
    input  data,
    input  valid,
    output ready,
    input  frame_error,
    input  overflow
  );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin synchronizers, clock deglitch filter,
// 11-bit frame deframer with parity/stop checks and a one-entry output register.
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 96000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_receiver_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Bit 0 carries the clock pin, bit 1 the data pin.
  logic [1:0] raw_pins;
  logic [1:0] sync_pins;
  assign raw_pins = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          s1_reg <= 1'b1;
          s2_reg <= 1'b1;
        end else begin
          s1_reg <= raw_pins[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_pins[gi] = s2_reg;
    end
  endgenerate

  logic clk_sync;
  logic data_sync;
  assign clk_sync  = sync_pins[0];
  assign data_sync = sync_pins[1];

  logic [7:0] filt_cnt_reg;
  logic       filt_clk_reg;
  logic       filt_prev_reg;
  logic       fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_reg  <= 8'd0;
      filt_clk_reg  <= 1'b1;
      filt_prev_reg <= 1'b1;
    end else begin
      filt_prev_reg <= filt_clk_reg;
      if (clk_sync != filt_clk_reg) begin
        if (filt_cnt_reg == 8'(FILTER_LEN - 1)) begin
          filt_clk_reg <= clk_sync;
          filt_cnt_reg <= 8'd0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 8'd1;
        end
      end else begin
        filt_cnt_reg <= 8'd0;
      end
    end
  end

  assign fall = filt_prev_reg & ~filt_clk_reg;

  state_t          state_reg, state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            parity_reg, parity_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic            error_reg, error_next;
  logic            deliver_reg, deliver_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'd0;
      parity_reg  <= 1'b0;
      tmo_reg     <= '0;
      error_reg   <= 1'b0;
      deliver_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tmo_reg     <= tmo_next;
      error_reg   <= error_next;
      deliver_reg <= deliver_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    error_next   = 1'b0;
    deliver_next = 1'b0;
    tmo_next     = (state_reg == IDLE || fall) ? '0 : tmo_reg + TW'(1);

    if (state_reg != IDLE && !fall && tmo_reg == TW'(TIMEOUT_CYCLES - 1)) begin
      state_next = IDLE;
      error_next = 1'b1;
      tmo_next   = '0;
    end else if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!data_sync) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end else begin
            error_next = 1'b1;
          end
        end
        DATA: begin
          shift_next   = {data_sync, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_next = data_sync;
          state_next  = STOP;
        end
        STOP: begin
          // Odd parity: data bits plus parity bit must hold an odd number of ones.
          if (data_sync && (^{shift_reg, parity_reg})) begin
            deliver_next = 1'b1;
          end else begin
            error_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  logic [7:0] data_reg;
  logic       valid_reg;
  logic       overflow_reg;

  // shift_reg is untouched in IDLE, so it still holds the byte one cycle after STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg     <= 8'd0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= 1'b0;
      if (deliver_reg) begin
        if (!valid_reg || rx.ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end else if (valid_reg && rx.ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx.data        = data_reg;
  assign rx.valid       = valid_reg;
  assign rx.frame_error = error_reg;
  assign rx.overflow    = overflow_reg;

endmodule
